// File: rtl/clk_gen_pkg.sv
// Shared constants and types for the clock-generator downsampler slice.
// Imported by clk_gen_ds_counter and clk_gen_downsampler.
package clk_gen_pkg;

    localparam int unsigned clk_gen_ds_width_gp     = 8;
    localparam int unsigned clk_gen_ds_reset_div_lp = 0;

    // Level of the divided clock; the phase register is the clk_o flop itself.
    typedef enum logic {
        PHASE_LOW  = 1'b0,
        PHASE_HIGH = 1'b1
    } ds_phase_e;

endpackage

// File: rtl/clk_gen_ds_counter.sv
// Divide counter and 50%-duty toggle flop; flags the high->low boundary where
// a pending divide value may be swapped in without shortening any phase.
module clk_gen_ds_counter
    import clk_gen_pkg::*;
#(
    parameter int unsigned WIDTH = clk_gen_ds_width_gp
) (
    input  logic             clk_i,
    input  logic             async_reset_i,
    input  logic             apply_v_i,
    input  logic [WIDTH-1:0] apply_div_i,
    output logic             clk_o,
    output logic             boundary_o,
    output logic [WIDTH-1:0] cur_div_o
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(clk_gen_ds_reset_div_lp);

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] div_r;
    ds_phase_e        phase_r;
    ds_phase_e        phase_n;
    logic             wrap;

    assign wrap = (cnt_r == div_r);

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            phase_r <= PHASE_LOW;
        end else begin
            phase_r <= phase_n;
        end
    end

    always_comb begin
        phase_n    = phase_r;
        boundary_o = 1'b0;
        case (phase_r)
            PHASE_LOW: begin
                if (wrap) begin
                    phase_n = PHASE_HIGH;
                end
            end
            PHASE_HIGH: begin
                if (wrap) begin
                    phase_n    = PHASE_LOW;
                    boundary_o = 1'b1;
                end
            end
            default: begin
                phase_n = PHASE_LOW;
            end
        endcase
    end

    // cnt_r restarts on the same edge a new div_r lands, so it never exceeds div_r.
    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            cnt_r <= '0;
        end else if (wrap) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            div_r <= RESET_DIV;
        end else if (boundary_o && apply_v_i) begin
            div_r <= apply_div_i;
        end
    end

    assign clk_o     = (phase_r == PHASE_HIGH);
    assign cur_div_o = div_r;

endmodule

// File: rtl/clk_gen_downsampler.sv
// Programmable 50%-duty clock downsampler: valid/ready load of divide value N,
// applied only at the end of a full output period (period = 2*(N+1)).
module clk_gen_downsampler
    import clk_gen_pkg::*;
#(
    parameter int unsigned WIDTH = clk_gen_ds_width_gp
) (
    input  logic             clk_i,
    input  logic             async_reset_i,
    input  logic             ds_val_i,
    input  logic [WIDTH-1:0] ds_data_i,
    output logic             ds_ready_o,
    output logic             clk_o,
    output logic [WIDTH-1:0] cur_div_o
);

    logic [WIDTH-1:0] pend_r;
    logic             pend_v_r;
    logic             boundary;
    logic             accept;

    // Ready is a pure flop output; a value accepted now waits for the next boundary.
    assign ds_ready_o = ~pend_v_r;
    assign accept     = ds_val_i & ds_ready_o;

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            pend_r   <= '0;
            pend_v_r <= 1'b0;
        end else if (accept) begin
            pend_r   <= ds_data_i;
            pend_v_r <= 1'b1;
        end else if (boundary && pend_v_r) begin
            pend_v_r <= 1'b0;
        end
    end

    clk_gen_ds_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk_i        (clk_i),
        .async_reset_i(async_reset_i),
        .apply_v_i    (pend_v_r),
        .apply_div_i  (pend_r),
        .clk_o        (clk_o),
        .boundary_o   (boundary),
        .cur_div_o    (cur_div_o)
    );

endmodule

// File: tb/tb_clk_gen_downsampler.sv
// Directed bench for clk_gen_downsampler: expected clk_o phases are queued as
// stimulus is applied and compared against phases measured by a monitor.
module tb_clk_gen_downsampler;

    import clk_gen_pkg::*;

    localparam int unsigned W = clk_gen_ds_width_gp;

    logic         clk_i    = 1'b0;
    logic         rst      = 1'b1;
    logic         ds_val   = 1'b0;
    logic [W-1:0] ds_data  = '0;
    logic         ds_ready;
    logic         clk_o;
    logic [W-1:0] cur_div;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        level;
        int unsigned len;
        string       tag;
    } exp_t;

    typedef struct {
        logic        level;
        int unsigned len;
    } ph_t;

    exp_t exp_q[$];
    ph_t  obs_q[$];

    int unsigned rec_limit = 0;
    int unsigned rec_taken = 0;

    always #5 clk_i = ~clk_i;

    clk_gen_downsampler #(
        .WIDTH(W)
    ) dut (
        .clk_i        (clk_i),
        .async_reset_i(rst),
        .ds_val_i     (ds_val),
        .ds_data_i    (ds_data),
        .ds_ready_o   (ds_ready),
        .clk_o        (clk_o),
        .cur_div_o    (cur_div)
    );

    // Phase monitor: samples on the falling clk_i edge, records completed phases
    // whose start fell inside an armed recording window.
    initial begin
        logic        m_prev;
        int unsigned m_run;
        bit          m_live;
        bit          m_rec;
        ph_t         p;
        m_prev = 1'b0;
        m_run  = 0;
        m_live = 1'b0;
        m_rec  = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst) begin
                m_prev = 1'b0;
                m_run  = 0;
                m_live = 1'b0;
                m_rec  = 1'b0;
            end else if (clk_o !== m_prev) begin
                if (m_live && m_rec) begin
                    p.level = m_prev;
                    p.len   = m_run;
                    obs_q.push_back(p);
                end
                m_live = 1'b1;
                m_run  = 1;
                m_prev = clk_o;
                m_rec  = (rec_taken < rec_limit);
                if (m_rec) rec_taken++;
            end else begin
                m_run++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic level, input int unsigned len, input string tag);
        exp_t e;
        e.level = level;
        e.len   = len;
        e.tag   = tag;
        exp_q.push_back(e);
    endtask

    task automatic arm(input int unsigned n);
        rec_limit = rec_taken + n;
    endtask

    task automatic drain(input int unsigned limit, input string tag);
        int unsigned n;
        exp_t e;
        ph_t  o;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            if (obs_q.size() != 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                assert (o.level === e.level && o.len == e.len) else begin
                    failures++;
                    $error("FAIL %s level=%0d len=%0d expected level=%0d len=%0d",
                           e.tag, o.level, o.len, e.level, e.len);
                end
            end else begin
                tick();
                n++;
            end
        end
        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL %s_timeout observed_pending=%0d expected_pending=0", tag, exp_q.size());
        end
        exp_q.delete();
        obs_q.delete();
        rec_limit = rec_taken;
    endtask

    // Stops one sample after clk_o reaches to_level from the opposite level.
    task automatic wait_edge(input logic to_level, input int unsigned limit, input string tag);
        logic p;
        bit   found;
        found = 1'b0;
        p     = clk_o;
        for (int unsigned n = 0; n < limit && !found; n++) begin
            tick();
            if (p !== to_level && clk_o === to_level) found = 1'b1;
            p = clk_o;
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL %s_timeout observed=not_seen expected=edge_to_%0d", tag, to_level);
        end
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_clk_o",   32'(clk_o),    32'd0);
        chk("rst_ready",   32'(ds_ready), 32'd1);
        chk("rst_cur_div", 32'(cur_div),  32'd0);
        #2 rst = 1'b0;
        tick();
        chk("first_rise", 32'(clk_o), 32'd1);
        wait_edge(1'b0, 4, "t1_fall");
        push(1'b0, 1, "t1_low"); push(1'b1, 1, "t1_high");
        push(1'b0, 1, "t1_low"); push(1'b1, 1, "t1_high");
        arm(4);
        drain(20, "t1");

        // Load N=3; offer 5 while it is pending
        wait_edge(1'b0, 4, "t2_fall");
        ds_val  = 1'b1;
        ds_data = 8'd3;
        tick();
        chk("t2_ready_low",    32'(ds_ready), 32'd0);
        chk("t2_div_not_yet",  32'(cur_div),  32'd0);
        chk("t2_clk_high",     32'(clk_o),    32'd1);
        ds_data = 8'd5;
        tick();
        ds_val  = 1'b0;
        chk("t3_div_applied",  32'(cur_div),  32'd3);
        chk("t3_apply_at_fall", 32'(clk_o),   32'd0);
        chk("t3_ready_back",   32'(ds_ready), 32'd1);
        push(1'b0, 4, "t2_low"); push(1'b1, 4, "t2_high");
        push(1'b0, 4, "t2_low"); push(1'b1, 4, "t2_high");
        arm(4);
        drain(60, "t2");
        chk("t3_div_not_5",    32'(cur_div),  32'd3);
        chk("t3_ready_idle",   32'(ds_ready), 32'd1);

        // Async reset in the 2nd cycle of a high phase
        wait_edge(1'b1, 20, "t5_rise");
        tick();
        chk("t5_high_before_rst", 32'(clk_o), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_clk_o",   32'(clk_o),    32'd0);
        chk("t5_rst_cur_div", 32'(cur_div),  32'd0);
        chk("t5_rst_ready",   32'(ds_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_first_rise", 32'(clk_o), 32'd1);
        wait_edge(1'b0, 4, "t5_fall");
        push(1'b0, 1, "t5_low"); push(1'b1, 1, "t5_high");
        push(1'b0, 1, "t5_low"); push(1'b1, 1, "t5_high");
        arm(4);
        drain(20, "t5");

        // Back to N=3, then load N=0 on the edge where clk_o rises
        wait_edge(1'b0, 4, "t6_sync");
        ds_val  = 1'b1;
        ds_data = 8'd3;
        tick();
        ds_val  = 1'b0;
        tick();
        chk("t6_reload3", 32'(cur_div), 32'd3);
        push(1'b0, 4, "t6_old_low"); push(1'b1, 4, "t6_old_high");
        push(1'b0, 1, "t6_new_low"); push(1'b1, 1, "t6_new_high");
        push(1'b0, 1, "t6_new_low");
        arm(5);
        repeat (3) tick();
        ds_val  = 1'b1;
        ds_data = 8'd0;
        tick();
        ds_val  = 1'b0;
        chk("t6_accept_at_rise", 32'(clk_o),    32'd1);
        chk("t6_ready_low",      32'(ds_ready), 32'd0);
        chk("t6_div_held",       32'(cur_div),  32'd3);
        drain(60, "t6");
        chk("t6_div_now_0", 32'(cur_div),  32'd0);
        chk("t6_ready_back", 32'(ds_ready), 32'd1);

        // N=255, then reload the same value with no visible change
        wait_edge(1'b0, 4, "t4_sync");
        ds_val  = 1'b1;
        ds_data = 8'd255;
        tick();
        ds_val  = 1'b0;
        tick();
        chk("t4_div_255", 32'(cur_div), 32'd255);
        chk("t4_at_fall", 32'(clk_o),   32'd0);
        push(1'b0, 256, "t4_low"); push(1'b1, 256, "t4_high");
        push(1'b0, 256, "t4_low_reloaded");
        arm(3);
        ds_val  = 1'b1;
        ds_data = 8'd255;
        tick();
        ds_val  = 1'b0;
        chk("t4_reload_ready_low", 32'(ds_ready), 32'd0);
        drain(1000, "t4");
        chk("t4_div_still_255", 32'(cur_div),  32'd255);
        chk("t4_ready_back",    32'(ds_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
